// File: rtl/timer_arb_pkg.sv
// Shared encodings for the timer arbiter: FSM states and prescaler width.
package timer_arb_pkg;

    localparam int PRESC_W = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 1..TICK_DIV counter while run is high; tick_o marks the wrap cycle.
module tick_prescaler
    import timer_arb_pkg::*;
#(
    parameter logic [PRESC_W-1:0] TICK_DIV = 28'h2FA_F080
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick_o
);

    logic [PRESC_W-1:0] cnt;

    assign tick_o = run && (cnt == TICK_DIV);

    // Parked at 1 while idle, so a fresh grant always starts a full tick period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= PRESC_W'(1);
        else if (!run || tick_o)
            cnt <= PRESC_W'(1);
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of one tick-based countdown timer shared by N_REQ clients.
// Build option TIMER_ARB_ABORT_EN: owner dropping req during RUN releases the timer without done.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int                 N_REQ    = 4,
    parameter int                 DLY_W    = 8,
    parameter logic [PRESC_W-1:0] TICK_DIV = 28'h2FA_F080
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DLY_W-1:0] dly,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   tick
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state, state_nx;
    logic [IDX_W-1:0] rr_ptr, rr_nx;
    logic [IDX_W-1:0] owner, owner_nx;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [DLY_W-1:0] remaining, rem_nx;
    logic [DLY_W-1:0] dly_sel;
    logic [N_REQ-1:0] gnt_nx, done_nx;
    logic [N_REQ-1:0] pick_oh, owner_oh;
    logic             busy_nx;
    logic             run, wrap;
    int               j;

    assign run      = (state == ST_RUN);
    assign pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
    assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .tick_o (wrap)
    );

    // First pending request at or above rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        dly_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick == IDX_W'(i)) dly_sel = dly[i*DLY_W +: DLY_W];
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        rem_nx   = remaining;
        gnt_nx   = gnt;
        busy_nx  = busy;
        done_nx  = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    rr_nx    = (pick == IDX_W'(N_REQ-1)) ? '0 : pick + 1'b1;
                    owner_nx = pick;
                    // A zero delay expires on the spot: no grant, straight to done.
                    if (dly_sel == '0) begin
                        done_nx  = pick_oh;
                        state_nx = ST_DONE;
                    end else begin
                        gnt_nx   = pick_oh;
                        busy_nx  = 1'b1;
                        rem_nx   = dly_sel;
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
`ifdef TIMER_ARB_ABORT_EN
                if (!req[owner]) begin
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end else
`endif
                if (wrap) begin
                    rem_nx = remaining - 1'b1;
                    if (remaining == DLY_W'(1)) begin
                        gnt_nx   = '0;
                        busy_nx  = 1'b0;
                        done_nx  = owner_oh;
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            remaining <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            owner     <= owner_nx;
            remaining <= rem_nx;
            gnt       <= gnt_nx;
            done      <= done_nx;
            busy      <= busy_nx;
            tick      <= wrap;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (N_REQ=4, DLY_W=8, TICK_DIV=4); done pulses go through a scoreboard.
module tb_timer_arbiter;

    localparam int         N_REQ    = 4;
    localparam int         DLY_W    = 8;
    localparam logic [27:0] TICK_DIV = 28'd4;

    typedef struct {
        logic [N_REQ-1:0] vec;
        int               cyc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DLY_W-1:0] dly;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   tick;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   b;
    exp_t sb[$];
    exp_t e_mon;

    timer_arbiter #(
        .N_REQ    (N_REQ),
        .DLY_W    (DLY_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dly  (dly),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .tick (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        nclk(1);
        rst = 1'b0;
        nclk(1);
    endtask

    // Every done pulse must match the head of the scoreboard in vector and cycle.
    always @(negedge clk) begin
        if (done !== '0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 32'(done), 32'h0);
            end else begin
                e_mon = sb.pop_front();
                chk("sb_done_vec", 32'(done), 32'(e_mon.vec));
                chk("sb_done_cyc", 32'(cyc), 32'(e_mon.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        dly = '0;
        nclk(2);
        chk("rst_gnt",  32'(gnt),  32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        rst = 1'b0;
        nclk(1);

        // single client, 3 ticks
        b = cyc;
        req = 4'b0001;
        dly = '0;
        dly[7:0] = 8'd3;
        sb.push_back('{4'b0001, b + 13});
        for (int k = 1; k <= 13; k++) begin
            nclk(1);
            chk($sformatf("t1_gnt_c%0d", k),  32'(gnt),  (k <= 12) ? 32'h1 : 32'h0);
            chk($sformatf("t1_busy_c%0d", k), 32'(busy), (k <= 12) ? 32'h1 : 32'h0);
            chk($sformatf("t1_tick_c%0d", k), 32'(tick),
                (k == 5 || k == 9 || k == 13) ? 32'h1 : 32'h0);
        end
        req = '0;
        nclk(2);

        // all clients pending, 1 tick each, rr from 0
        rst_pulse();
        b = cyc;
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) dly[i*DLY_W +: DLY_W] = 8'd1;
        sb.push_back('{4'b0001, b + 5});
        sb.push_back('{4'b0010, b + 11});
        sb.push_back('{4'b0100, b + 17});
        sb.push_back('{4'b1000, b + 23});
        sb.push_back('{4'b0001, b + 29});
        for (int k = 1; k <= 29; k++) begin
            nclk(1);
            chk($sformatf("t2_gnt_c%0d", k), 32'(gnt),
                (((k - 1) % 6) < 4) ? (32'h1 << (((k - 1) / 6) % 4)) : 32'h0);
        end
        req = '0;
        nclk(2);

        // zero delay: immediate done, no grant; then IDLE accepts a new request
        b = cyc;
        req = 4'b0100;
        dly = '0;
        sb.push_back('{4'b0100, b + 1});
        nclk(1);
        chk("t3_gnt_c1",  32'(gnt),  32'h0);
        chk("t3_busy_c1", 32'(busy), 32'h0);
        req = '0;
        nclk(1);
        chk("t3_gnt_c2", 32'(gnt), 32'h0);
        req = 4'b0001;
        dly[7:0] = 8'd1;
        sb.push_back('{4'b0001, b + 7});
        for (int k = 3; k <= 7; k++) begin
            nclk(1);
            chk($sformatf("t3_regnt_c%0d", k), 32'(gnt), (k <= 6) ? 32'h1 : 32'h0);
        end
        req = '0;
        nclk(2);

        // owner drops req mid-countdown
        b = cyc;
        req = 4'b0001;
        dly = '0;
        dly[7:0] = 8'd5;
`ifndef TIMER_ARB_ABORT_EN
        sb.push_back('{4'b0001, b + 21});
`endif
        for (int k = 1; k <= 22; k++) begin
            nclk(1);
`ifdef TIMER_ARB_ABORT_EN
            chk($sformatf("t4_gnt_c%0d", k),  32'(gnt),  (k <= 6) ? 32'h1 : 32'h0);
            chk($sformatf("t4_busy_c%0d", k), 32'(busy), (k <= 6) ? 32'h1 : 32'h0);
`else
            chk($sformatf("t4_gnt_c%0d", k),  32'(gnt),  (k <= 20) ? 32'h1 : 32'h0);
            chk($sformatf("t4_busy_c%0d", k), 32'(busy), (k <= 20) ? 32'h1 : 32'h0);
`endif
            if (k == 6) req = '0;
        end
        nclk(2);

        // async reset during RUN, then regrant after release
        b = cyc;
        req = 4'b0010;
        dly = '0;
        dly[15:8] = 8'd2;
        for (int k = 1; k <= 5; k++) begin
            nclk(1);
            chk($sformatf("t5_gnt_c%0d", k), 32'(gnt), 32'h2);
        end
        nclk(1);
        rst = 1'b1;
        #1;
        chk("t5_rst_gnt",  32'(gnt),  32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_tick", 32'(tick), 32'h0);
        chk("t5_rst_done", 32'(done), 32'h0);
        nclk(2);
        rst = 1'b0;
        sb.push_back('{4'b0010, b + 17});
        nclk(1);
        chk("t5_regnt_busy_c9", 32'(busy), 32'h1);
        chk("t5_regnt_gnt_c9",  32'(gnt),  32'h2);
        for (int k = 10; k <= 17; k++) begin
            nclk(1);
            chk($sformatf("t5_gnt_c%0d", k), 32'(gnt), (k <= 16) ? 32'h2 : 32'h0);
        end
        req = '0;
        nclk(2);

        // dly change after grant is ignored
        b = cyc;
        req = 4'b0010;
        dly = '0;
        dly[15:8] = 8'd2;
        sb.push_back('{4'b0010, b + 9});
        for (int k = 1; k <= 9; k++) begin
            nclk(1);
            chk($sformatf("t6_gnt_c%0d", k), 32'(gnt), (k <= 8) ? 32'h2 : 32'h0);
            if (k == 3) dly[15:8] = 8'd9;
        end
        req = '0;
        nclk(3);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
